// File: rtl/sck_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sck_alu_seq
//  Purpose  : Sequential command front-end for the 10-bit combinational ALU.
//             Accepts one operation per valid/ready command handshake. It
//             registers the operands and opcode towards the ALU, captures the
//             ALU result and flags one cycle later, and returns them on a
//             valid/ready response channel. It also keeps an accumulator, a
//             sticky overflow bit and a wrapping completed-operation counter.
//  Ports    :
//    i_clk, i_rst              clock (rising edge), synchronous active-high reset
//    i_cmd_valid/o_cmd_ready   command handshake
//    i_cmd_oper/a/b/acc        opcode, operands, use-accumulator select
//    o_alu_arg0/arg1/oper      registered drive to the ALU
//    i_alu_result/i_alu_flag   combinational ALU outputs {NEG,POS,ZERO,OVF}
//    o_rsp_valid/i_rsp_ready   response handshake
//    o_rsp_result/flag/err     response payload
//    o_acc                     accumulator
//    o_sticky_ovf/i_clr_sticky sticky overflow and its clear
//    o_op_count                completed responses, wraps
//  Revision : 1.0  initial release
// ============================================================================
module sck_alu_seq #(
   parameter int W     = 10,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   // command channel
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [2:0]       i_cmd_oper,
   input  logic [W-1:0]     i_cmd_a,
   input  logic [W-1:0]     i_cmd_b,
   input  logic             i_cmd_acc,
   // ALU side
   output logic [W-1:0]     o_alu_arg0,
   output logic [W-1:0]     o_alu_arg1,
   output logic [2:0]       o_alu_oper,
   input  logic [W-1:0]     i_alu_result,
   input  logic [3:0]       i_alu_flag,
   // response channel
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [W-1:0]     o_rsp_result,
   output logic [3:0]       o_rsp_flag,
   output logic             o_rsp_err,
   // status
   output logic [W-1:0]     o_acc,
   output logic             o_sticky_ovf,
   input  logic             i_clr_sticky,
   output logic [CNT_W-1:0] o_op_count
);

   localparam logic [2:0] c_OPER_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [W-1:0]      r_arg0;
   logic [W-1:0]      r_arg1;
   logic [2:0]        r_oper;
   logic              r_err;
   logic [W-1:0]      r_rsp_result;
   logic [3:0]        r_rsp_flag;
   logic [W-1:0]      r_acc;
   logic              r_sticky;
   logic [CNT_W-1:0]  r_count;

   logic              w_cmd_fire;
   logic              w_rsp_fire;
   logic              w_in_exec;
   logic [W-1:0]      w_cap_result;
   logic [3:0]        w_cap_flag;

   // ------------------------------------------------------------------------
   // Next-state and handshake outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      o_cmd_ready = 1'b0;
      o_rsp_valid = 1'b0;
      w_in_exec   = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            // ALU inputs have been stable all cycle; result is captured at
            // the closing edge, so EXEC always lasts exactly one cycle.
            w_in_exec   = 1'b1;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_cmd_fire = i_cmd_valid & o_cmd_ready;
   assign w_rsp_fire = o_rsp_valid & i_rsp_ready;

   // An illegal opcode never reaches the response or status path: the ALU
   // output is ignored and replaced by an all-zero result and flag word.
   assign w_cap_result = r_err ? '0    : i_alu_result;
   assign w_cap_flag   = r_err ? 4'b0  : i_alu_flag;

   // ------------------------------------------------------------------------
   // State register and datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_arg0       <= '0;
         r_arg1       <= '0;
         r_oper       <= '0;
         r_err        <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_flag   <= '0;
         r_acc        <= '0;
         r_sticky     <= 1'b0;
         r_count      <= '0;
      end else begin
         r_state <= w_state_nxt;

         // Operand capture; the accumulator is sampled at acceptance so a
         // chained op sees the result of the previous completed EXEC.
         if (w_cmd_fire) begin
            r_arg0 <= i_cmd_acc ? r_acc : i_cmd_a;
            r_arg1 <= i_cmd_b;
            r_oper <= i_cmd_oper;
            r_err  <= (i_cmd_oper == c_OPER_ILLEGAL);
         end

         // Result capture. The accumulator updates here, independent of
         // whether the consumer has taken the response yet.
         if (w_in_exec) begin
            r_rsp_result <= w_cap_result;
            r_rsp_flag   <= w_cap_flag;
            if (!r_err) begin
               r_acc <= w_cap_result;
            end
         end

         // Sticky overflow: a new overflow wins over a simultaneous clear.
         if (w_in_exec && w_cap_flag[0]) begin
            r_sticky <= 1'b1;
         end else if (i_clr_sticky) begin
            r_sticky <= 1'b0;
         end

         if (w_rsp_fire) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign o_alu_arg0   = r_arg0;
   assign o_alu_arg1   = r_arg1;
   assign o_alu_oper   = r_oper;
   assign o_rsp_result = r_rsp_result;
   assign o_rsp_flag   = r_rsp_flag;
   assign o_rsp_err    = r_err;
   assign o_acc        = r_acc;
   assign o_sticky_ovf = r_sticky;
   assign o_op_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sck_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sck_alu_seq
//  Purpose  : Directed self-checking bench for sck_alu_seq with a small
//             behavioural model of the combinational ALU attached. A second
//             instance with a 3-bit counter exercises counter wrap cheaply.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sck_alu_seq;

   localparam int W = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic [2:0]    cmd_oper;
   logic [W-1:0]  cmd_a;
   logic [W-1:0]  cmd_b;
   logic          cmd_acc;
   logic          rsp_ready;
   logic          clr_sticky;
   logic [W-1:0]  alu_result;
   logic [3:0]    alu_flag;

   logic          cmd_ready;
   logic [W-1:0]  alu_arg0;
   logic [W-1:0]  alu_arg1;
   logic [2:0]    alu_oper;
   logic          rsp_valid;
   logic [W-1:0]  rsp_result;
   logic [3:0]    rsp_flag;
   logic          rsp_err;
   logic [W-1:0]  acc;
   logic          sticky;
   logic [15:0]   op_count;

   logic          s_cmd_ready;
   logic [W-1:0]  s_alu_arg0;
   logic [W-1:0]  s_alu_arg1;
   logic [2:0]    s_alu_oper;
   logic          s_rsp_valid;
   logic [W-1:0]  s_rsp_result;
   logic [3:0]    s_rsp_flag;
   logic          s_rsp_err;
   logic [W-1:0]  s_acc;
   logic          s_sticky;
   logic [2:0]    s_op_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sck_alu_seq #(.W(W), .CNT_W(16)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_oper(cmd_oper), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_acc(cmd_acc),
      .o_alu_arg0(alu_arg0), .o_alu_arg1(alu_arg1), .o_alu_oper(alu_oper),
      .i_alu_result(alu_result), .i_alu_flag(alu_flag),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_result(rsp_result), .o_rsp_flag(rsp_flag), .o_rsp_err(rsp_err),
      .o_acc(acc), .o_sticky_ovf(sticky), .i_clr_sticky(clr_sticky),
      .o_op_count(op_count)
   );

   // Same stimulus, small counter: used only for the wrap check.
   sck_alu_seq #(.W(W), .CNT_W(3)) u_small (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(s_cmd_ready),
      .i_cmd_oper(cmd_oper), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_acc(cmd_acc),
      .o_alu_arg0(s_alu_arg0), .o_alu_arg1(s_alu_arg1), .o_alu_oper(s_alu_oper),
      .i_alu_result(alu_result), .i_alu_flag(alu_flag),
      .o_rsp_valid(s_rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_result(s_rsp_result), .o_rsp_flag(s_rsp_flag), .o_rsp_err(s_rsp_err),
      .o_acc(s_acc), .o_sticky_ovf(s_sticky), .i_clr_sticky(clr_sticky),
      .o_op_count(s_op_count)
   );

   // Behavioural ALU. Opcode 7 returns garbage so that a missing error
   // override shows up in the response.
   always_comb begin
      alu_result = '0;
      alu_flag   = 4'b0;
      case (alu_oper)
         3'd0: alu_result = alu_arg0 + alu_arg1;
         3'd1: alu_result = alu_arg0 - alu_arg1;
         3'd2: alu_result = alu_arg0 << alu_arg1[3:0];
         3'd3: alu_result = alu_arg0 & alu_arg1;
         3'd4: alu_result = alu_arg0 | alu_arg1;
         3'd5: alu_result = alu_arg0 ^ alu_arg1;
         3'd6: alu_result = ~(alu_arg0 ^ alu_arg1);
         default: alu_result = '1;
      endcase
      if (alu_oper == 3'd7) begin
         alu_flag = 4'b1111;
      end else begin
         alu_flag[3] = alu_result[W-1];
         alu_flag[1] = (alu_result == '0);
         alu_flag[2] = !alu_result[W-1] && (alu_result != '0);
         if (alu_oper == 3'd0)
            alu_flag[0] = (alu_arg0[W-1] == alu_arg1[W-1]) && (alu_result[W-1] != alu_arg0[W-1]);
         else if (alu_oper == 3'd1)
            alu_flag[0] = (alu_arg0[W-1] != alu_arg1[W-1]) && (alu_result[W-1] != alu_arg0[W-1]);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a command for one accepting edge; returns in EXEC.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic use_acc);
      cmd_valid = 1'b1;
      cmd_oper  = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_acc   = use_acc;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_acc"},   32'(acc),       32'd0);
      chk({tag, "_count"}, 32'(op_count),  32'd0);
      chk({tag, "_stky"},  32'(sticky),    32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_oper = '0; cmd_a = '0; cmd_b = '0;
      cmd_acc = 1'b0; rsp_ready = 1'b1; clr_sticky = 1'b0;
      step(); step();
      rst = 1'b0;

      // Reset state
      check_reset_state("rst");
      chk("rst_arg0", 32'(alu_arg0),   32'd0);
      chk("rst_res",  32'(rsp_result), 32'd0);
      chk("rst_err",  32'(rsp_err),    32'd0);

      // 1: ADD 100 + 50
      issue(3'd0, 10'd100, 10'd50, 1'b0);
      chk("t1_ready_exec", 32'(cmd_ready), 32'd0);
      chk("t1_arg0",       32'(alu_arg0),  32'd100);
      chk("t1_arg1",       32'(alu_arg1),  32'd50);
      chk("t1_valid_exec", 32'(rsp_valid), 32'd0);
      step();
      chk("t1_valid",      32'(rsp_valid),  32'd1);
      chk("t1_ready_resp", 32'(cmd_ready),  32'd0);
      chk("t1_res",        32'(rsp_result), 32'd150);
      chk("t1_flag",       32'(rsp_flag),   32'h4);
      chk("t1_err",        32'(rsp_err),    32'd0);
      chk("t1_acc",        32'(acc),        32'd150);
      step();
      chk("t1_count",      32'(op_count),   32'd1);
      chk("t1_idle_ready", 32'(cmd_ready),  32'd1);

      // 2: SUB using accumulator (150 - 150)
      issue(3'd1, 10'd7, 10'd150, 1'b1);
      chk("t2_arg0", 32'(alu_arg0), 32'd150);
      step();
      chk("t2_res",  32'(rsp_result), 32'd0);
      chk("t2_flag", 32'(rsp_flag),   32'h2);
      chk("t2_acc",  32'(acc),        32'd0);
      step();

      // 3: ADD 300 + 300 overflows to -424 (10'h258)
      issue(3'd0, 10'd300, 10'd300, 1'b0);
      step();
      chk("t3_res",  32'(rsp_result), 32'h258);
      chk("t3_flag", 32'(rsp_flag),   32'h9);
      chk("t3_stky", 32'(sticky),     32'd1);
      step();
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      chk("t3_clr", 32'(sticky), 32'd0);
      issue(3'd0, 10'd300, 10'd300, 1'b0);
      clr_sticky = 1'b1;            // high across the EXEC-end edge
      step();
      clr_sticky = 1'b0;
      chk("t3_set_wins", 32'(sticky), 32'd1);
      step();
      chk("t3_count", 32'(op_count), 32'd4);

      // 4: XOR with response backpressure and ignored command pulses
      rsp_ready = 1'b0;
      issue(3'd5, 10'h0F0, 10'h0FF, 1'b0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t4_valid", 32'(rsp_valid),  32'd1);
         chk("t4_res",   32'(rsp_result), 32'h00F);
         chk("t4_flag",  32'(rsp_flag),   32'h4);
         cmd_valid = i[0];
         cmd_oper  = 3'd0;
         cmd_a     = 10'd1;
         cmd_b     = 10'd1;
         cmd_acc   = 1'b0;
         step();
      end
      cmd_valid = 1'b0;
      chk("t4_still_valid", 32'(rsp_valid), 32'd1);
      chk("t4_arg0_held",   32'(alu_arg0),  32'h0F0);
      chk("t4_count_hold",  32'(op_count),  32'd4);
      rsp_ready = 1'b1;
      step();
      chk("t4_count", 32'(op_count), 32'd5);
      chk("t4_acc",   32'(acc),      32'h00F);
      chk("t4_idle",  32'(cmd_ready), 32'd1);

      // 5: illegal opcode
      issue(3'd7, 10'd5, 10'd5, 1'b0);
      step();
      chk("t5_res",  32'(rsp_result), 32'd0);
      chk("t5_flag", 32'(rsp_flag),   32'd0);
      chk("t5_err",  32'(rsp_err),    32'd1);
      chk("t5_acc",  32'(acc),        32'h00F);
      chk("t5_stky", 32'(sticky),     32'd1);
      step();
      chk("t5_count", 32'(op_count), 32'd6);

      // 6: reset during EXEC, then during RESP
      issue(3'd3, 10'd3, 10'd1, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state("t6_exec");
      issue(3'd4, 10'h00A, 10'h005, 1'b0);
      step();
      chk("t6_pre_valid", 32'(rsp_valid), 32'd1);
      chk("t6_pre_acc",   32'(acc),       32'h00F);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state("t6_resp");

      // Counter wrap on the 3-bit instance: 7 ops -> 7, one more -> 0
      for (int i = 0; i < 7; i++) begin
         issue(3'd0, 10'(i), 10'd1, 1'b0);
         step();
         step();
      end
      chk("wrap_pre", 32'(s_op_count), 32'd7);
      issue(3'd0, 10'd9, 10'd1, 1'b0);
      step();
      step();
      chk("wrap_zero", 32'(s_op_count), 32'd0);
      chk("wrap_main", 32'(op_count),   32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
